// File: rtl/slave_rx_ctrl.sv
// slave_rx_ctrl
//   Slave-side handshake controller for the chip-to-chip link. A master
//   request starts a notice window of DELAY_CYCLES cycles. After that window
//   ack rises and the block accepts a burst of DATA_W-bit words for as long
//   as the master holds valid.
//   The block also provides a data-wait timeout, saturating word counting
//   and a sticky overflow flag. Every output is registered.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   request      : master request (level)
//   valid        : master data-valid (level)
//   data_in      : master data word
//   ack          : acknowledge to master
//   notice       : high while the notice delay runs
//   data         : last accepted word
//   data_stb     : one-cycle pulse per accepted word
//   word_cnt     : words accepted in the current or last burst
//   overflow     : sticky, set when a word arrives after MAX_WORDS were accepted
//   timeout_err  : sticky, set when the data wait expired without valid
//   busy         : controller is not idle
module slave_rx_ctrl #(
  parameter int DATA_W         = 3,
  parameter int DELAY_CYCLES   = 100000000,
  parameter int TIMEOUT_CYCLES = 200000000,
  parameter int MAX_WORDS      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           request,
  input  logic                           valid,
  input  logic [DATA_W-1:0]              data_in,
  output logic                           ack,
  output logic                           notice,
  output logic [DATA_W-1:0]              data,
  output logic                           data_stb,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_cnt,
  output logic                           overflow,
  output logic                           timeout_err,
  output logic                           busy
);

  localparam int CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int WC_W    = $clog2(MAX_WORDS+1);

  typedef enum logic [1:0] {IDLE, DELAY, WAIT_DATA, RECV} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              notice_q, notice_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stb_q, stb_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              ovf_q, ovf_d;
  logic              terr_q, terr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    notice_d = notice_q;
    data_d   = data_q;
    stb_d    = 1'b0;
    wc_d     = wc_q;
    ovf_d    = ovf_q;
    terr_d   = terr_q;
    unique case (state_q)
      IDLE: begin
        ack_d    = 1'b0;
        notice_d = 1'b0;
        cnt_d    = '0;
        if (request) begin
          // A new request wipes the results of the previous burst.
          state_d  = DELAY;
          notice_d = 1'b1;
          data_d   = '0;
          wc_d     = '0;
          ovf_d    = 1'b0;
          terr_d   = 1'b0;
        end
      end
      DELAY: begin
        // The request is committed here, so request is not looked at.
        if (cnt_q == CNT_W'(DELAY_CYCLES-1)) begin
          state_d  = WAIT_DATA;
          notice_d = 1'b0;
          ack_d    = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DATA: begin
        if (valid) begin
          state_d = RECV;
          data_d  = data_in;
          stb_d   = 1'b1;
          wc_d    = WC_W'(1);
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          terr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        if (valid) begin
          if (wc_q < WC_W'(MAX_WORDS)) begin
            data_d = data_in;
            stb_d  = 1'b1;
            wc_d   = wc_q + WC_W'(1);
          end else begin
            // The word is dropped. data and word_cnt keep the last accepted values.
            ovf_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      notice_q <= 1'b0;
      data_q   <= '0;
      stb_q    <= 1'b0;
      wc_q     <= '0;
      ovf_q    <= 1'b0;
      terr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      notice_q <= notice_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
      wc_q     <= wc_d;
      ovf_q    <= ovf_d;
      terr_q   <= terr_d;
      busy_q   <= busy_d;
    end
  end

  assign ack         = ack_q;
  assign notice      = notice_q;
  assign data        = data_q;
  assign data_stb    = stb_q;
  assign word_cnt    = wc_q;
  assign overflow    = ovf_q;
  assign timeout_err = terr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_slave_rx_ctrl.sv
// Bench for slave_rx_ctrl with DELAY=4, TIMEOUT=6, MAX_WORDS=3, DATA_W=3.
// A transaction-level model follows each burst by its age in cycles since
// the request was taken. The model's outputs are compared on every negedge.
// Directed checks with literal values pin the model.
module tb_slave_rx_ctrl;
  localparam int DW = 3, D = 4, T = 6, M = 3;

  logic clk = 1'b0;
  logic rst, request, valid;
  logic [DW-1:0] data_in, data;
  logic ack, notice, data_stb, overflow, timeout_err, busy;
  logic [1:0] word_cnt;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  slave_rx_ctrl #(.DATA_W(DW), .DELAY_CYCLES(D), .TIMEOUT_CYCLES(T), .MAX_WORDS(M)) dut (
    .clk(clk), .rst(rst), .request(request), .valid(valid), .data_in(data_in),
    .ack(ack), .notice(notice), .data(data), .data_stb(data_stb), .word_cnt(word_cnt),
    .overflow(overflow), .timeout_err(timeout_err), .busy(busy));

  always #5 clk = ~clk;

  // ---- model: one burst is tracked by its age since the request ----
  bit active, recv, m_ovf, m_terr, m_stb;
  int age, words;
  logic [DW-1:0] m_data;

  always @(posedge clk) begin
    m_stb = 0;
    if (rst) begin
      active = 0; recv = 0; age = 0; words = 0; m_data = 0; m_ovf = 0; m_terr = 0;
    end else if (!active) begin
      if (request) begin
        active = 1; recv = 0; age = 0; words = 0; m_data = 0; m_ovf = 0; m_terr = 0;
      end
    end else begin
      age++;
      if (age > D) begin            // ack window: the inputs matter
        if (!recv) begin
          if (valid) begin
            recv = 1; words = 1; m_data = data_in; m_stb = 1;
          end else if (age - D == T) begin
            active = 0; m_terr = 1;
          end
        end else if (valid) begin
          if (words < M) begin
            words++; m_data = data_in; m_stb = 1;
          end else m_ovf = 1;
        end else active = 0;
      end
    end
  end

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp("m_ack",    ack,         int'(active && age >= D));
    cmp("m_notice", notice,      int'(active && age < D));
    cmp("m_busy",   busy,        int'(active));
    cmp("m_data",   data,        m_data);
    cmp("m_stb",    data_stb,    m_stb);
    cmp("m_wcnt",   word_cnt,    words);
    cmp("m_ovf",    overflow,    m_ovf);
    cmp("m_terr",   timeout_err, m_terr);
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for ack and counts the notice cycles seen before it. The wait is bounded.
  task automatic wait_ack(output int ncnt);
    ncnt = 0;
    for (int i = 0; i < 20 && !ack; i++) begin
      if (notice) ncnt++;
      step(1);
    end
    if (!ack) begin
      errors++;
      $display("FAIL wait_ack ack never rose t=%0t", $time);
    end
  endtask

  int n, stbs;

  initial begin
    rst = 1; request = 0; valid = 0; data_in = 0;
    step(1);
    chk_en = 1;
    step(1);
    rst = 0;
    cmp("rst_ack", ack, 0); cmp("rst_data", data, 0); cmp("rst_busy", busy, 0);
    cmp("rst_wcnt", word_cnt, 0);

    // Single word. request is a one-cycle pulse, so it drops during DELAY.
    request = 1; step(1); request = 0;
    wait_ack(n);
    cmp("notice_len", n, 4);
    valid = 1; data_in = 3'b101; step(1);
    cmp("sw_data", data, 5); cmp("sw_stb", data_stb, 1); cmp("sw_wcnt", word_cnt, 1);
    valid = 0; step(1);
    cmp("sw_ack_fall", ack, 0); cmp("sw_stb_off", data_stb, 0); cmp("sw_hold", data, 5);

    // Burst of 5 words with MAX_WORDS=3.
    step(1);
    request = 1; step(1); request = 0;
    wait_ack(n);
    stbs = 0;
    for (int w = 1; w <= 5; w++) begin
      valid = 1; data_in = DW'(w); step(1);
      stbs += data_stb;
      if (w == 3) cmp("b_ovf_pre", overflow, 0);
      if (w == 4) cmp("b_ovf_set", overflow, 1);
    end
    valid = 0; step(1);
    cmp("b_data", data, 3); cmp("b_wcnt", word_cnt, 3); cmp("b_stbs", stbs, 3);
    cmp("b_ovf", overflow, 1);

    // Timeout. The request that starts it must also clear overflow.
    request = 1; step(1); request = 0;
    cmp("ovf_clr", overflow, 0);
    wait_ack(n);
    step(5);
    cmp("to_ack_hold", ack, 1);
    step(1);
    cmp("to_ack", ack, 0); cmp("to_err", timeout_err, 1); cmp("to_busy", busy, 0);
    request = 1; step(1);
    cmp("terr_clr", timeout_err, 0);

    // Back-to-back. request is held through the whole burst.
    wait_ack(n);
    valid = 1; data_in = 3'd2; step(1);
    valid = 0; step(1);
    cmp("bb_ack", ack, 0); cmp("bb_gap_notice", notice, 0);
    step(1);
    cmp("bb_notice", notice, 1);
    request = 0;

    // Reset in the middle of RECV.
    wait_ack(n);
    valid = 1; data_in = 3'd6; step(1);
    data_in = 3'd7; step(1);
    cmp("mr_wcnt2", word_cnt, 2);
    rst = 1; step(1); rst = 0; valid = 0;
    cmp("mr_ack", ack, 0); cmp("mr_data", data, 0); cmp("mr_wcnt", word_cnt, 0);
    cmp("mr_busy", busy, 0); cmp("mr_notice", notice, 0);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
